tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of digital_video: one TMDS channel of an incoming DVI stream at the 25 MHz pixel clock.
- Takes the unaligned 10-bit parallel word from a 1:10 deserializer and finds the symbol boundary by searching for control tokens.
- Decodes each aligned symbol into 8-bit pixel data, data-enable and the 2 control bits.
- Three instances (blue/green/red) feed a downstream timing-recovery block that uses ctrl on the blue channel as hsync/vsync.

---
 rtl/tmds_channel_decoder.sv | 147 ++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds the 10-bit symbol boundary in the raw
// deserializer word by hunting for control tokens, then decodes aligned
// symbols into pixel data, data-enable and the two control bits.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 2048
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  input  logic [9:0] sym_in,
  output logic [7:0] data,
  output logic       de,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] slip_pos
);

  localparam int TIMER_MAX = (LOSS_TIMEOUT > SEARCH_TIMEOUT) ? LOSS_TIMEOUT : SEARCH_TIMEOUT;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int RW        = $clog2(LOCK_COUNT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t          state;
  logic [9:0]      prev;
  logic [9:0]      aligned;
  logic [9:0]      window;
  logic [19:0]     w;
  logic [RW-1:0]   run;
  logic [TW-1:0]   timer;
  logic            is_token;
  logic [1:0]      tok_ctrl;
  logic [7:0]      t;
  logic [7:0]      dec;
  logic [3:0]      next_slip;

  // Two consecutive raw words cover every possible symbol position.
  assign w         = {sym_in, prev};
  assign window    = 10'(w >> slip_pos);
  assign next_slip = (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;

  // Recognise the four control tokens in the stage-1 aligned symbol.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    is_token = 1'b1;
    tok_ctrl = 2'b00;
    case (aligned)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    dec = '0;
    t   = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dec[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aligned[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

  // Stage 1: keep the previous word and register the selected window.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    if (rst) begin
      prev    <= '0;
      aligned <= '0;
    end else begin
      prev    <= sym_in;
      aligned <= window;
    end
  end

  // Stage 2: decode into registered outputs, forced quiet until locked.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      data <= '0;
      de   <= 1'b0;
      ctrl <= 2'b00;
    end else if (!locked) begin
      data <= '0;
      de   <= 1'b0;
      ctrl <= 2'b00;
    end else if (is_token) begin
      data <= '0;
      de   <= 1'b0;
      ctrl <= tok_ctrl;
    end else begin
      data <= dec;
      de   <= 1'b1;
    end
  end

  // Alignment FSM: count token runs at one offset, slip on timeout,
  // and drop lock when tokens stop arriving.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      locked   <= 1'b0;
      slip_pos <= 4'd0;
      run      <= '0;
      timer    <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (run == RW'(LOCK_COUNT)) begin
            // Lock takes priority over a coincident search timeout.
            state  <= LOCKED;
            locked <= 1'b1;
            run    <= '0;
            timer  <= '0;
          end else if (timer == TW'(SEARCH_TIMEOUT - 1)) begin
            slip_pos <= next_slip;
            run      <= '0;
            timer    <= '0;
          end else begin
            timer <= timer + TW'(1);
            if (is_token) run <= run + RW'(1);
            else          run <= '0;
          end
        end
        LOCKED: begin
          if (is_token) begin
            timer <= '0;
          end else if (timer == TW'(LOSS_TIMEOUT - 1)) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            slip_pos <= next_slip;
            run      <= '0;
            timer    <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: line-structured DVI stream generator with
// optional bit rotation, plus a scoreboard of expected decoded outputs.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T0 = 10'h354;
  localparam logic [9:0] T1 = 10'h0AB;
  localparam logic [9:0] T2 = 10'h154;
  localparam logic [9:0] T3 = 10'h2AB;

  logic       clk_25mhz = 1'b0;
  logic       rst;
  logic [9:0] sym_in;
  logic [7:0] data;
  logic       de;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] slip_pos;

  tmds_channel_decoder dut (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .sym_in    (sym_in),
    .data      (data),
    .de        (de),
    .ctrl      (ctrl),
    .locked    (locked),
    .slip_pos  (slip_pos)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int edges = 0;
  always @(posedge clk_25mhz) edges <= edges + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          due;
    logic [10:0] val;
  } exp_t;

  exp_t       sbq[$];
  bit         sb_on = 1'b0;
  logic [1:0] last_ctrl;
  logic [9:0] prev_s;
  int         line_idx;
  int         rel_edge;
  int         chg_pos[$];
  int         chg_at[$];
  int         used;
  int         n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the TMDS symbol definition.
  function automatic logic [10:0] model(input logic [9:0] q, input logic [1:0] lc);
    logic [7:0] tt;
    logic [7:0] d;
    case (q)
      T0: return {1'b0, 2'b00, 8'h00};
      T1: return {1'b0, 2'b01, 8'h00};
      T2: return {1'b0, 2'b10, 8'h00};
      T3: return {1'b0, 2'b11, 8'h00};
      default: ;
    endcase
    tt = q[9] ? ~q[7:0] : q[7:0];
    d[0] = tt[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (tt[i] ^ tt[i-1]) : ~(tt[i] ^ tt[i-1]);
    return {1'b1, lc, d};
  endfunction

  function automatic logic [9:0] line_sym(input int idx);
    int p;
    p = idx % 800;
    if (p >= 640) return T0;
    case (p % 5)
      0:       return 10'h100;
      1:       return 10'h200;
      2:       return 10'h101;
      3:       return 10'h2F0;
      default: return 10'h155;
    endcase
  endfunction

  // Symbol captured on the next edge appears on the outputs two edges later.
  task automatic push(input logic [10:0] v);
    exp_t e;
    e.due = edges + 3;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [9:0] wd);
    sym_in = wd;
    @(posedge clk_25mhz);
    #1;
  endtask

  // Serialise symbol s, presenting it rotated by k bits across word pairs.
  task automatic send(input logic [9:0] s, input int k);
    logic [19:0] c;
    logic [10:0] e;
    c = {s, prev_s};
    prev_s = s;
    if (sb_on && k == 0) begin
      e = model(s, last_ctrl);
      if (!e[10]) last_ctrl = e[9:8];
      push(e);
    end
    drive(10'(c >> (10 - k)));
  endtask

  task automatic send_exp(input logic [9:0] s, input logic [10:0] e);
    prev_s = s;
    push(e);
    drive(s);
  endtask

  task automatic run_stream(input int k, input int max_cycles, input bit stop_on_lock, output int cnt);
    logic [3:0] last_pos;
    last_pos = slip_pos;
    cnt = 0;
    for (int i = 0; i < max_cycles; i++) begin
      send(line_sym(line_idx), k);
      line_idx++;
      cnt++;
      if (slip_pos != last_pos) begin
        chg_pos.push_back(int'(slip_pos));
        chg_at.push_back(edges);
        last_pos = slip_pos;
      end
      if (stop_on_lock && locked) break;
    end
  endtask

  // Reset is raised between edges and must clear outputs without a clock.
  task automatic apply_reset();
    @(posedge clk_25mhz);
    #7;
    rst = 1'b1;
    #1;
    check("rst_now", {locked, slip_pos, de, ctrl, data}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(T0);
      check("rst_hold", {locked, slip_pos, de, ctrl, data}, 32'h0);
    end
    @(negedge clk_25mhz);
    rst = 1'b0;
    sbq.delete();
    sb_on = 1'b0;
    prev_s = '0;
    last_ctrl = 2'b00;
    chg_pos.delete();
    chg_at.delete();
    rel_edge = edges;
  endtask

  // Scoreboard: compare each expected entry on the falling edge it is due.
  always @(negedge clk_25mhz) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == edges) begin
      e = sbq.pop_front();
      check("decode", {21'h0, de, ctrl, data}, {21'h0, e.val});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sym_in = '0;
    prev_s = '0;
    last_ctrl = 2'b00;
    line_idx = 0;
    apply_reset();

    // Aligned stream starting at blanking.
    line_idx = 640;
    run_stream(0, 20, 1'b1, used);
    check("lock_within_11", (used <= 11), 1);
    check("locked_aligned", locked, 1);
    check("slip_aligned", slip_pos, 0);
    check("no_slip_aligned", chg_pos.size(), 0);

    // Full line through the scoreboard.
    sb_on = 1'b1;
    last_ctrl = 2'b00;
    run_stream(0, 800, 1'b0, used);
    sb_on = 1'b0;

    // Directed decode vectors with hand-derived results.
    send_exp(T0,      {1'b0, 2'b00, 8'h00});
    send_exp(10'h100, {1'b1, 2'b00, 8'h00});
    send_exp(10'h200, {1'b1, 2'b00, 8'hFF});
    send_exp(10'h101, {1'b1, 2'b00, 8'h03});
    send_exp(T1,      {1'b0, 2'b01, 8'h00});
    send_exp(10'h100, {1'b1, 2'b01, 8'h00});
    send_exp(T2,      {1'b0, 2'b10, 8'h00});
    send_exp(T3,      {1'b0, 2'b11, 8'h00});
    send_exp(10'h200, {1'b1, 2'b11, 8'hFF});
    send_exp(T0,      {1'b0, 2'b00, 8'h00});
    prev_s = T0;
    for (int i = 0; i < 4; i++) send(T0, 0);
    check("sb_drained", sbq.size(), 0);

    // Loss of lock: data symbols only.
    check("pre_loss_locked", locked, 1);
    n = 0;
    while (locked && n < 2100) begin
      send(10'h200, 0);
      n++;
    end
    check("loss_time", (n >= 2048 && n <= 2051), 1);
    check("loss_unlocked", locked, 0);
    check("loss_slip", slip_pos, 1);
    send(10'h200, 0);
    check("loss_gated", {de, ctrl, data}, 32'h0);

    // Search from offset 1 wraps through 9 back to 0.
    chg_pos.delete();
    chg_at.delete();
    run_stream(0, 11000, 1'b1, used);
    check("wrap_steps", chg_pos.size(), 9);
    for (int i = 0; i < chg_pos.size() && i < 9; i++) begin
      check("wrap_pos", chg_pos[i], (i + 2) % 10);
      if (i > 0) check("wrap_interval", chg_at[i] - chg_at[i-1], 1024);
    end
    check("wrap_locked", locked, 1);
    check("wrap_slip0", slip_pos, 0);

    // Reset while locked.
    apply_reset();

    // Stream rotated by 3 bits.
    line_idx = 0;
    run_stream(3, 5000, 1'b1, used);
    check("rot3_steps", chg_pos.size(), 3);
    for (int i = 0; i < chg_pos.size() && i < 3; i++) begin
      check("rot3_pos", chg_pos[i], i + 1);
      if (i == 0) check("rot3_first", chg_at[0] - rel_edge, 1024);
      else        check("rot3_interval", chg_at[i] - chg_at[i-1], 1024);
    end
    check("rot3_locked", locked, 1);
    check("rot3_slip", slip_pos, 3);
    run_stream(3, 800, 1'b0, used);
    check("rot3_hold_locked", locked, 1);
    check("rot3_hold_slip", slip_pos, 3);

    // Stream rotated by 9 bits.
    apply_reset();
    line_idx = 0;
    run_stream(9, 11000, 1'b1, used);
    check("rot9_steps", chg_pos.size(), 9);
    check("rot9_locked", locked, 1);
    check("rot9_slip", slip_pos, 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
